// File: rtl/vga_sync_generator.sv
// VGA raster timing generator: pixel-rate divider, column/row counters and
// registered sync, display-enable and line/frame start strobes.
module vga_sync_generator #(
    parameter int DISP_COLS = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int DISP_ROWS = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] col_counter,
    output logic [11:0] row_counter,
    output logic        hsync,
    output logic        vsync,
    output logic        disp_en,
    output logic        pix_tick,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = DISP_COLS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = DISP_ROWS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] COL_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] ROW_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_BEG   = 12'(DISP_COLS + H_FP);
    localparam logic [11:0] HS_END   = 12'(DISP_COLS + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_BEG   = 12'(DISP_ROWS + V_FP);
    localparam logic [11:0] VS_END   = 12'(DISP_ROWS + V_FP + V_SYNC - 1);
    localparam logic [11:0] COLS     = 12'(DISP_COLS);
    localparam logic [11:0] ROWS     = 12'(DISP_ROWS);

    logic [DIV_W-1:0] div;
    logic             adv;
    logic [11:0]      col_next;
    logic [11:0]      row_next;

    // Last clk of a pixel period. Gated by rst_n so that with CLK_DIV=1
    // the tick still reads 0 while reset is held.
    assign adv      = (div == DIV_LAST);
    assign pix_tick = rst_n & adv;

    // Next raster position: column advances per pixel, row on column wrap.
    always_comb begin
        col_next = col_counter;
        row_next = row_counter;
        if (adv) begin
            if (col_counter == COL_LAST) begin
                col_next = '0;
                if (row_counter == ROW_LAST) begin
                    row_next = '0;
                end else begin
                    row_next = row_counter + 12'd1;
                end
            end else begin
                col_next = col_counter + 12'd1;
            end
        end
    end

    // Pixel-rate divider, free-running 0..CLK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (adv) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Counters plus decodes computed from the next position, so the
    // registered syncs line up with the counters with no skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_counter <= COL_LAST;
            row_counter <= ROW_LAST;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            disp_en     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            col_counter <= col_next;
            row_counter <= row_next;
            hsync       <= !((col_next >= HS_BEG) && (col_next <= HS_END));
            vsync       <= !((row_next >= VS_BEG) && (row_next <= VS_END));
            disp_en     <= (col_next < COLS) && (row_next < ROWS);
            line_start  <= adv && (col_counter == COL_LAST);
            frame_start <= adv && (col_counter == COL_LAST) && (row_counter == ROW_LAST);
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: two instances (CLK_DIV=2 with default line
// timing and a short frame, CLK_DIV=1 with a tiny raster), an elapsed-time
// raster model compared every cycle, and directed literal checks.
module tb_vga_sync_generator;

    typedef struct packed {
        logic [11:0] col;
        logic [11:0] row;
        logic        hs;
        logic        vs;
        logic        de;
        logic        pt;
        logic        ls;
        logic        fs;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [11:0] col_a, row_a, col_b, row_b;
    logic hs_a, vs_a, de_a, pt_a, ls_a, fs_a;
    logic hs_b, vs_b, de_b, pt_b, ls_b, fs_b;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    vga_sync_generator #(
        .DISP_ROWS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .col_counter(col_a), .row_counter(row_a),
        .hsync(hs_a), .vsync(vs_a), .disp_en(de_a),
        .pix_tick(pt_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_sync_generator #(
        .DISP_COLS(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .DISP_ROWS(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .col_counter(col_b), .row_counter(row_b),
        .hsync(hs_b), .vsync(vs_b), .disp_en(de_b),
        .pix_tick(pt_b), .line_start(ls_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raster position follows from clk edges elapsed since reset release:
    // every cd edges one pixel, the first pixel lands on (0,0).
    function automatic exp_t model(input int tt, input bit in_rst,
                                   input int dc, input int hfp, input int hsw, input int hbp,
                                   input int dr, input int vfp, input int vsw, input int vbp,
                                   input int cd);
        int h, v, p, lin, c, r;
        exp_t e;
        h = dc + hfp + hsw + hbp;
        v = dr + vfp + vsw + vbp;
        p = tt / cd;
        if (p == 0) begin
            c = h - 1;
            r = v - 1;
        end else begin
            lin = (p - 1) % (h * v);
            c = lin % h;
            r = lin / h;
        end
        e.col = 12'(c);
        e.row = 12'(r);
        e.hs  = !(c >= dc + hfp && c < dc + hfp + hsw);
        e.vs  = !(r >= dr + vfp && r < dr + vfp + vsw);
        e.de  = (c < dc) && (r < dr);
        e.pt  = !in_rst && ((tt % cd) == cd - 1);
        e.ls  = (p > 0) && ((tt % cd) == 0) && (c == 0);
        e.fs  = e.ls && (r == 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(t, !rst_n, 640, 16, 96, 48, 4, 1, 2, 1, 2);
        eb = model(t, !rst_n, 10, 2, 3, 4, 5, 1, 2, 2, 1);
        check("cyc_a", 32'({col_a, row_a, hs_a, vs_a, de_a, pt_a, ls_a, fs_a}), 32'(ea));
        check("cyc_b", 32'({col_b, row_b, hs_b, vs_b, de_b, pt_b, ls_b, fs_b}), 32'(eb));
    end

    task automatic wait_a(input int c, input int r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (col_a == 12'(c) && row_a == 12'(r)) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_pos_a", 32'(ok), 32'd1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int cyc, vlow, hlow, lines, ptlow, stuck;
        logic [11:0] prev;
        bit ok;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_a", 32'({col_a, row_a, hs_a, vs_a, de_a, pt_a, ls_a, fs_a}),
              32'({12'd799, 12'd7, 6'b110000}));
        check("rst_b", 32'({col_b, row_b, pt_b, ls_b, fs_b}), 32'({12'd18, 12'd9, 3'b000}));

        @(negedge clk); #1 rst_n = 1'b1;
        #1;
        check("rel_a", 32'({col_a, de_a, pt_a}), 32'({12'd799, 2'b00}));
        check("rel_pt_b", 32'(pt_b), 32'd1);
        @(posedge clk); #1;
        check("edge1_a", 32'({col_a, row_a, pt_a, fs_a}), 32'({12'd799, 12'd7, 2'b10}));
        check("edge1_b", 32'({col_b, row_b, fs_b, ls_b}), 32'({12'd0, 12'd0, 2'b11}));
        @(posedge clk); #1;
        check("edge2_a", 32'({col_a, row_a, de_a, fs_a, ls_a}), 32'({12'd0, 12'd0, 3'b111}));
        check("edge2_b", 32'({col_b, fs_b, ls_b}), 32'({12'd1, 2'b00}));
        @(posedge clk); #1;
        check("edge3_a", 32'({col_a, de_a, fs_a, ls_a}), 32'({12'd0, 3'b100}));

        // CLK_DIV=1 instance: frame period, tick always high, column always moving.
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fs_b) begin ok = 1'b1; break; end
        end
        check("wait_fs_b", 32'(ok), 32'd1);
        cyc = 0; ptlow = 0; stuck = 0; prev = col_b;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            cyc++;
            if (!pt_b) ptlow++;
            if (col_b == prev) stuck++;
            prev = col_b;
            if (fs_b) break;
        end
        check("frame_b_clk", 32'(cyc), 32'd190);
        check("pt_low_b", 32'(ptlow), 32'd0);
        check("col_stuck_b", 32'(stuck), 32'd0);

        // Horizontal sync edges and width.
        wait_a(655, 0); check("hs_655", 32'(hs_a), 32'd1);
        wait_a(656, 0); check("hs_656", 32'(hs_a), 32'd0);
        wait_a(751, 0); check("hs_751", 32'(hs_a), 32'd0);
        wait_a(752, 0); check("hs_752", 32'(hs_a), 32'd1);
        wait_a(0, 1);
        hlow = 0;
        for (int i = 0; i < 1600; i++) begin
            if (!hs_a) hlow++;
            @(negedge clk);
        end
        check("hs_low_clk", 32'(hlow), 32'd192);

        // Display-enable boundaries and row increment on column wrap.
        wait_a(639, 3); check("de_639_3", 32'(de_a), 32'd1);
        wait_a(640, 3); check("de_640_3", 32'(de_a), 32'd0);
        wait_a(799, 3);
        repeat (2) @(negedge clk);
        check("wrap_row", 32'({col_a, row_a, de_a, ls_a}), 32'({12'd0, 12'd4, 2'b01}));

        // One full frame: period, vsync low time, line count.
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (fs_a) begin ok = 1'b1; break; end
        end
        check("wait_fs_a", 32'(ok), 32'd1);
        cyc = 0; vlow = 0; lines = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            cyc++;
            if (!vs_a) vlow++;
            if (ls_a) lines++;
            if (fs_a) break;
        end
        check("frame_a_clk", 32'(cyc), 32'd12800);
        check("vs_low_clk", 32'(vlow), 32'd3200);
        check("lines_a", 32'(lines), 32'd8);

        wait_a(799, 7);
        repeat (2) @(negedge clk);
        check("frame_wrap", 32'({col_a, row_a, fs_a, ls_a}), 32'({12'd0, 12'd0, 2'b11}));

        // Asynchronous reset in the middle of a line.
        wait_a(300, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_a", 32'({col_a, row_a, hs_a, vs_a, de_a, pt_a, ls_a, fs_a}),
              32'({12'd799, 12'd7, 6'b110000}));
        check("mid_rst_b", 32'({col_b, row_b, pt_b}), 32'({12'd18, 12'd9, 1'b0}));
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("re_rel_a", 32'({col_a, pt_a, fs_a}), 32'({12'd799, 2'b00}));
        @(posedge clk); #1;
        check("re_edge1_a", 32'({col_a, pt_a, fs_a}), 32'({12'd799, 2'b10}));
        @(posedge clk); #1;
        check("re_edge2_a", 32'({col_a, row_a, fs_a, ls_a}), 32'({12'd0, 12'd0, 2'b11}));

        repeat (200) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 Parameter DISP_COLS, default 640, SHALL set visible pixels per line.
REQ-002 Parameter H_FP, default 16, SHALL set horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, SHALL set horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, SHALL set horizontal back porch in pixels.
REQ-005 Parameter DISP_ROWS, default 480, SHALL set visible lines per frame.
REQ-006 Parameter V_FP, default 10, SHALL set vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, SHALL set vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, SHALL set vertical back porch in lines.
REQ-009 Parameter CLK_DIV, default 2, SHALL set clk cycles per pixel, legal range 1..8.
REQ-010 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-011 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-012 col_counter  output  12  SHALL be the current pixel column, 0..H_TOTAL-1.
REQ-013 row_counter  output  12  SHALL be the current line, 0..V_TOTAL-1.
REQ-014 hsync  output  1  SHALL be horizontal sync, active low.
REQ-015 vsync  output  1  SHALL be vertical sync, active low.
REQ-016 disp_en  output  1  SHALL be high while the current position is visible.
REQ-017 pix_tick  output  1  SHALL be high in the last clk cycle of each pixel period.
REQ-018 line_start  output  1  SHALL pulse for one clk cycle at the start of each line.
REQ-019 frame_start  output  1  SHALL pulse for one clk cycle at the start of each frame.

Function
REQ-020 H_TOTAL SHALL equal DISP_COLS+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL equal DISP_ROWS+V_FP+V_SYNC+V_BP (default 525).
REQ-021 An internal divider SHALL count 0..CLK_DIV-1 and wrap; pix_tick SHALL be high exactly when the divider equals CLK_DIV-1, so pix_tick is constant 1 when CLK_DIV=1.
REQ-022 col_counter SHALL increment on each edge where pix_tick=1 and SHALL wrap from H_TOTAL-1 to 0.
REQ-023 row_counter SHALL increment only on the edge where col_counter wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-024 hsync SHALL be 0 iff DISP_COLS+H_FP <= col_counter <= DISP_COLS+H_FP+H_SYNC-1 (default 656..751).
REQ-025 vsync SHALL be 0 iff DISP_ROWS+V_FP <= row_counter <= DISP_ROWS+V_FP+V_SYNC-1 (default 490..491).
REQ-026 disp_en SHALL be 1 iff col_counter < DISP_COLS and row_counter < DISP_ROWS.
REQ-027 hsync, vsync and disp_en SHALL be registered and SHALL correspond to the col_counter/row_counter values present in the same cycle, with zero cycles of skew.
REQ-028 line_start SHALL be 1 only in the first clk cycle in which col_counter=0.
REQ-029 frame_start SHALL be 1 only in the first clk cycle in which col_counter=0 and row_counter=0, and SHALL coincide with line_start.
REQ-030 Exactly H_TOTAL*V_TOTAL*CLK_DIV clk cycles SHALL separate consecutive frame_start pulses (default 840000).
REQ-031 Counters SHALL never hold a value >= H_TOTAL or >= V_TOTAL.

Reset
REQ-032 While rst_n=0, without waiting for a clock edge, outputs SHALL be: col_counter=H_TOTAL-1, row_counter=V_TOTAL-1, hsync=1, vsync=1, disp_en=0, pix_tick=0, line_start=0, frame_start=0; divider=0.
REQ-033 After rst_n rises, the first pixel advance SHALL occur after CLK_DIV clk edges, moving counters to (0,0) and pulsing frame_start and line_start.
REQ-034 Assertion of rst_n mid-line or mid-frame SHALL discard all timing state with no partial pulses afterwards.

Verification
REQ-035 Release reset with defaults -> col=799, row=524, disp_en=0; 2 clk edges later col=0, row=0, disp_en=1, frame_start=line_start=1 for exactly one cycle.
REQ-036 Sweep one line -> hsync=1 at col 655, 0 at cols 656..751, 1 at col 752; low time of 192 clk.
REQ-037 Sweep one frame -> vsync low only on rows 490..491 (3200 clk); 840000 clk between frame_start pulses.
REQ-038 Boundary check -> disp_en=1 at (639,479), 0 at (640,479), 0 at (0,480); col 799->0 increments row; (799,524)->(0,0).
REQ-039 Drop rst_n at col=300, row=200 between clock edges -> outputs take REQ-032 values immediately; normal restart per REQ-033.
REQ-040 CLK_DIV=1 -> pix_tick=1 every cycle after reset; counters advance each clk; frame_start period 420000 clk.
